// File: rtl/cmd_uart_responder_if.sv
// Command-side handshake between the UART responder and the command processor.
interface cmd_uart_responder_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  resp;
  logic        tx_done;

  modport slave (
    input  clr_cmd_rdy, trmt, resp,
    output cmd, cmd_rdy, tx_done
  );

  modport master (
    output clr_cmd_rdy, trmt, resp,
    input  cmd, cmd_rdy, tx_done
  );
endinterface

// File: rtl/cmd_uart_responder.sv
// Knight-side UART endpoint: receives byte pairs into a 16-bit command and
// transmits single response bytes. RX and TX paths are fully independent.
module cmd_uart_responder #(
  parameter int BAUD_CNT = 2604
) (
  input  logic clk,
  input  logic rst,
  input  logic RX,
  output logic TX,
  cmd_uart_responder_if.slave bus
);
  localparam int BW = $clog2(BAUD_CNT) + 1;
  localparam logic [BW-1:0] FULL = BW'(BAUD_CNT - 1);
  localparam logic [BW-1:0] HALF = BW'(BAUD_CNT / 2 - 1);
  localparam logic [BW-1:0] ONE  = BW'(1);

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // ---------------- receiver ----------------
  rx_state_t       rx_state, rx_next;
  logic            rx_s1, rx_s2, rx_s3;
  logic [BW-1:0]   rx_baud;
  logic [3:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_rdy, rx_fall, rx_sample;

  assign rx_fall   = rx_s3 & ~rx_s2;
  assign rx_sample = (rx_state == RX_RECV) && (rx_baud == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (rx_fall) rx_next = RX_RECV;
      RX_RECV: if (rx_sample && ((rx_bit == 4'd0 && rx_s2) || rx_bit == 4'd9))
                 rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  // Idle preloads the half-bit count so the first sample lands mid start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      rx_rdy <= 1'b0;
      if (rx_state == RX_IDLE) begin
        rx_baud <= HALF;
        rx_bit  <= '0;
      end else if (rx_sample) begin
        rx_baud <= FULL;
        rx_bit  <= rx_bit + 4'd1;
        if (rx_bit >= 4'd1 && rx_bit <= 4'd8) rx_shift <= {rx_s2, rx_shift[7:1]};
        if (rx_bit == 4'd9 && rx_s2) rx_rdy <= 1'b1;
      end else begin
        rx_baud <= rx_baud - ONE;
      end
    end
  end

  // ---------------- byte-pair assembler ----------------
  asm_state_t asm_state, asm_next;
  logic       store_hi, store_lo, rdy_pend, cmd_rdy;
  logic [15:0] cmd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) asm_state <= WAIT_HI;
    else     asm_state <= asm_next;
  end

  always_comb begin
    asm_next = asm_state;
    store_hi = 1'b0;
    store_lo = 1'b0;
    if (rx_rdy) begin
      case (asm_state)
        WAIT_HI: begin store_hi = 1'b1; asm_next = WAIT_LO; end
        WAIT_LO: begin store_lo = 1'b1; asm_next = WAIT_HI; end
        default: asm_next = WAIT_HI;
      endcase
    end
  end

  // A pending set outranks both a clear request and a fresh high byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      rdy_pend <= 1'b0;
    end else begin
      rdy_pend <= store_lo;
      if (store_hi) cmd[15:8] <= rx_shift;
      if (store_lo) cmd[7:0]  <= rx_shift;
      if (rdy_pend)                          cmd_rdy <= 1'b1;
      else if (store_hi || bus.clr_cmd_rdy)  cmd_rdy <= 1'b0;
    end
  end

  assign bus.cmd     = cmd;
  assign bus.cmd_rdy = cmd_rdy;

  // ---------------- transmitter ----------------
  tx_state_t     tx_state, tx_next;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic [9:0]    tx_shift;
  logic          tx_q, tx_done, tx_last;

  assign tx_last = (tx_state == TX_SEND) && (tx_baud == '0) && (tx_bit == 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (bus.trmt) tx_next = TX_SEND;
      TX_SEND: if (tx_last)  tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q     <= 1'b1;
      tx_done  <= 1'b0;
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_bit   <= '0;
    end else if (tx_state == TX_IDLE) begin
      if (bus.trmt) begin
        tx_shift <= {1'b1, bus.resp, 1'b0};
        tx_q     <= 1'b0;
        tx_baud  <= FULL;
        tx_bit   <= '0;
        tx_done  <= 1'b0;
      end
    end else if (tx_baud == '0) begin
      tx_baud <= FULL;
      if (tx_last) begin
        tx_q    <= 1'b1;
        tx_done <= 1'b1;
      end else begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_q     <= tx_shift[1];
        tx_bit   <= tx_bit + 4'd1;
      end
    end else begin
      tx_baud <= tx_baud - ONE;
    end
  end

  assign TX          = tx_q;
  assign bus.tx_done = tx_done;
endmodule

// File: tb/tb_cmd_uart_responder.sv
// Self-checking bench for cmd_uart_responder at BAUD_CNT=16: vector table,
// directed corner sequences and randomized traffic against a byte-queue model.
module tb_cmd_uart_responder;
  localparam int B = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic tx;

  cmd_uart_responder_if bus();

  cmd_uart_responder #(.BAUD_CNT(B)) dut (
    .clk (clk),
    .rst (rst),
    .RX  (rx),
    .TX  (tx),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    bit          bad_mid;
    logic [15:0] exp;
  } vec_t;

  vec_t       tbl [4];
  logic [9:0] txbits;
  logic [7:0] q [$];
  bit         seen;
  int         len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (B) @(negedge clk);
    end
    rx = stop;
    repeat (B) @(negedge clk);
    rx = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  task automatic wait_rdy(output bit s);
    s = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.cmd_rdy) begin s = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit s);
    s = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.tx_done) begin s = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_trmt(input logic [7:0] r);
    @(negedge clk);
    bus.resp = r;
    bus.trmt = 1'b1;
    @(negedge clk);
    bus.trmt = 1'b0;
  endtask

  // Samples each TX bit at its centre once the start bit is seen.
  task automatic cap_tx(output logic [9:0] bits);
    int n;
    n = 0;
    bits = '1;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx === 1'b0) begin
      repeat (B / 2) @(negedge clk);
      bits[0] = tx;
      for (int i = 1; i < 10; i++) begin
        repeat (B) @(negedge clk);
        bits[i] = tx;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    bus.trmt = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp = '0;
    tbl[0] = '{hi: 8'h20, lo: 8'h00, bad_mid: 1'b0, exp: 16'h2000};
    tbl[1] = '{hi: 8'h00, lo: 8'h00, bad_mid: 1'b0, exp: 16'h0000};
    tbl[2] = '{hi: 8'hFF, lo: 8'hFF, bad_mid: 1'b1, exp: 16'hFFFF};
    tbl[3] = '{hi: 8'h80, lo: 8'h01, bad_mid: 1'b1, exp: 16'h8001};

    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_cmd", bus.cmd, 0);
    chk("reset_cmd_rdy", bus.cmd_rdy, 0);
    chk("reset_tx_done", bus.tx_done, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Vector table: pair reception, orphan high byte across a framing error, clear.
    for (int v = 0; v < 4; v++) begin
      send_byte(tbl[v].hi, 1'b1);
      if (tbl[v].bad_mid) send_byte(8'h41, 1'b0);
      chk("tbl_rdy_after_hi", bus.cmd_rdy, 0);
      send_byte(tbl[v].lo, 1'b1);
      wait_rdy(seen);
      chk("tbl_rdy_seen", seen, 1);
      chk("tbl_cmd", bus.cmd, tbl[v].exp);
      clr_pulse();
      chk("tbl_clr", bus.cmd_rdy, 0);
    end

    // Response A5 with a second trmt and resp change mid-frame.
    pulse_trmt(8'hA5);
    chk("tx_done_cleared", bus.tx_done, 0);
    fork
      cap_tx(txbits);
      begin
        len = 0;
        while (!bus.tx_done && len < 400) begin
          @(negedge clk);
          len++;
          if (len == 70) begin bus.resp = 8'hFF; bus.trmt = 1'b1; end
          if (len == 71) bus.trmt = 1'b0;
        end
      end
    join
    chk("tx_a5_bits", txbits, {1'b1, 8'hA5, 1'b0});
    chk("tx_a5_len", len, 10 * B);
    chk("tx_idle_high", tx, 1);

    // New high byte drops stale cmd_rdy; set beats a held clear.
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_rdy(seen);
    chk("stale_rdy_up", seen, 1);
    send_byte(8'h60, 1'b1);
    chk("stale_rdy_dropped", bus.cmd_rdy, 0);
    bus.clr_cmd_rdy = 1'b1;
    seen = 1'b0;
    fork
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 12 * B; i++) begin
        @(negedge clk);
        if (bus.cmd_rdy) seen = 1'b1;
      end
    join
    bus.clr_cmd_rdy = 1'b0;
    chk("set_beats_clr", seen, 1);
    chk("cmd_6000", bus.cmd, 16'h6000);

    // Framing error, then a pair; then a short glitch on idle RX.
    send_byte(8'h41, 1'b0);
    chk("frame_err_no_rdy", bus.cmd_rdy, 0);
    send_byte(8'h12, 1'b1);
    chk("rdy_low_after_12", bus.cmd_rdy, 0);
    send_byte(8'h34, 1'b1);
    wait_rdy(seen);
    chk("rdy_1234", seen, 1);
    chk("cmd_1234", bus.cmd, 16'h1234);
    @(negedge clk);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (3 * B) @(negedge clk);
    chk("glitch_rdy_kept", bus.cmd_rdy, 1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    wait_rdy(seen);
    chk("cmd_after_glitch", bus.cmd, 16'h5678);

    // Reset in the middle of an RX byte and a TX frame.
    pulse_trmt(8'hC3);
    rx = 1'b0;
    repeat (4 * B) @(negedge clk);
    chk("pre_rst_tx_low", tx, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_cmd_rdy", bus.cmd_rdy, 0);
    chk("rst_tx_done", bus.tx_done, 0);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (B) @(negedge clk);
    send_byte(8'hA5, 1'b1);
    send_byte(8'hA5, 1'b1);
    wait_rdy(seen);
    chk("post_rst_rdy", seen, 1);
    chk("post_rst_cmd", bus.cmd, 16'hA5A5);
    clr_pulse();

    // Full duplex.
    fork
      begin
        send_byte(8'h3C, 1'b1);
        send_byte(8'h5A, 1'b1);
      end
      begin
        pulse_trmt(8'h5A);
        cap_tx(txbits);
      end
    join
    wait_rdy(seen);
    chk("duplex_cmd", bus.cmd, 16'h3C5A);
    chk("duplex_tx", txbits, {1'b1, 8'h5A, 1'b0});
    wait_done(seen);
    chk("duplex_tx_done", seen, 1);
    clr_pulse();

    // Randomized traffic: valid bytes queue up and pair in arrival order.
    for (int it = 0; it < 8; it++) begin
      logic [7:0] hi, lo, r;
      bit bad;
      hi  = 8'($urandom);
      lo  = 8'($urandom);
      r   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      fork
        begin
          send_byte(hi, 1'b1);
          q.push_back(hi);
          if (bad) send_byte(8'($urandom), 1'b0);
          send_byte(lo, 1'b1);
          q.push_back(lo);
        end
        begin
          pulse_trmt(r);
          cap_tx(txbits);
        end
      join
      wait_rdy(seen);
      chk("rnd_rdy", seen, 1);
      if (q.size() == 2) begin
        chk("rnd_cmd", bus.cmd, {q[0], q[1]});
        q.delete();
      end
      chk("rnd_tx", txbits, {1'b1, r, 1'b0});
      wait_done(seen);
      chk("rnd_tx_done", seen, 1);
      clr_pulse();
      chk("rnd_clr", bus.cmd_rdy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
